// File: rtl/stochastic_neuron_core.sv
// Single-neuron stochastic core: saturating 12-bit accumulator, PWL sigmoid, 8-bit LFSR, Bernoulli sampler.
// Latency: accumulator/LFSR update each edge; prob_out combinational from acc; sample result one edge after request.
// Backpressure: none; every request is accepted and each sample request yields exactly one sample_valid pulse.
module stochastic_neuron_core #(
    parameter logic [11:0] INF  = 12'h7FF,
    parameter logic [7:0]  SEED = 8'd32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [11:0] load_value,
    input  logic        add_valid,
    input  logic [11:0] add_value,
    input  logic        sample,
    output logic [11:0] acc_out,
    output logic [7:0]  prob_out,
    output logic [7:0]  rnd_out,
    output logic        sample_valid,
    output logic        sample_bit
);

    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'd0) ? 8'h01 : SEED;

    // Saturation bounds expressed at the 13-bit sum width.
    localparam logic signed [12:0] POS_LIM = $signed({1'b0, INF});
    localparam logic signed [12:0] NEG_LIM = -$signed({1'b0, INF});

    logic [11:0] acc_q, acc_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        sample_valid_q, sample_valid_d;
    logic        sample_bit_q, sample_bit_d;

    logic signed [12:0] sum13;
    logic [11:0]        sat_sum;
    logic [11:0]        acc_abs;
    logic [8:0]         y_mag;
    logic [8:0]         y_sgn;
    logic [7:0]         prob;
    logic               lfsr_fb;

    // Accumulator next state: load beats add; the sum is widened one bit so overflow can be clamped.
    always_comb begin
        sum13   = $signed({acc_q[11], acc_q}) + $signed({add_value[11], add_value});
        sat_sum = sum13[11:0];
        if (sum13 > POS_LIM) begin
            sat_sum = POS_LIM[11:0];
        end else if (sum13 < NEG_LIM) begin
            sat_sum = NEG_LIM[11:0];
        end

        acc_d = acc_q;
        if (load_valid) begin
            acc_d = load_value;
        end else if (add_valid) begin
            acc_d = sat_sum;
        end
    end

    // Piecewise-linear sigmoid on |acc| (8 fraction bits), mirrored about 128 for negative inputs.
    always_comb begin
        // Unsigned magnitude; -2048 maps to 2048 (12'h800) without wrapping.
        acc_abs = acc_q[11] ? (~acc_q + 12'd1) : acc_q;

        if (acc_abs >= 12'd1280) begin
            y_mag = 9'd256;
        end else if (acc_abs >= 12'd608) begin
            y_mag = {2'b00, acc_abs[11:5]} + 9'd216;
        end else if (acc_abs >= 12'd256) begin
            y_mag = acc_abs[11:3] + 9'd160;
        end else begin
            y_mag = {3'b000, acc_abs[7:2]} + 9'd128;
        end

        y_sgn = acc_q[11] ? (9'd256 - y_mag) : y_mag;

        // 256 does not fit in 8 bits; it saturates to 255.
        prob = y_sgn[8] ? 8'hFF : y_sgn[7:0];
    end

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every clock.
    always_comb begin
        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
    end

    // Bernoulli sample from the pre-edge probability and random value; bit holds between requests.
    always_comb begin
        sample_valid_d = sample;
        sample_bit_d   = sample_bit_q;
        if (sample) begin
            sample_bit_d = (prob > lfsr_q);
        end
    end

    // State registers; reset clears everything and discards any in-flight sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q          <= 12'd0;
            lfsr_q         <= SEED_EFF;
            sample_valid_q <= 1'b0;
            sample_bit_q   <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            lfsr_q         <= lfsr_d;
            sample_valid_q <= sample_valid_d;
            sample_bit_q   <= sample_bit_d;
        end
    end

    assign acc_out      = acc_q;
    assign prob_out     = prob;
    assign rnd_out      = lfsr_q;
    assign sample_valid = sample_valid_q;
    assign sample_bit   = sample_bit_q;

endmodule

// File: tb/tb_stochastic_neuron_core.sv
// Directed bench for stochastic_neuron_core.
// Each scenario task drives its own stimulus and compares against hand-derived values.
// Clock period 10; inputs are driven and outputs observed 1 time unit after the rising edge.
module tb_stochastic_neuron_core;

    logic        clock;
    logic        reset;
    logic        load_valid;
    logic [11:0] load_value;
    logic        add_valid;
    logic [11:0] add_value;
    logic        sample;
    logic [11:0] acc_out;
    logic [7:0]  prob_out;
    logic [7:0]  rnd_out;
    logic        sample_valid;
    logic        sample_bit;

    int pass_cnt;
    int total_cnt;

    stochastic_neuron_core dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_value   (load_value),
        .add_valid    (add_valid),
        .add_value    (add_value),
        .sample       (sample),
        .acc_out      (acc_out),
        .prob_out     (prob_out),
        .rnd_out      (rnd_out),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent LFSR reference: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        load_valid = 1'b0;
        load_value = 12'd0;
        add_valid  = 1'b0;
        add_value  = 12'd0;
        sample     = 1'b0;
    endtask

    // Assert reset across an edge, release it at a falling edge.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #3;
        total_cnt++;
        if (acc_out !== 12'd0) $display("FAIL reset_acc acc_out=%0d expected=0", acc_out);
        else pass_cnt++;
        total_cnt++;
        if (prob_out !== 8'd128) $display("FAIL reset_prob prob_out=%0d expected=128", prob_out);
        else pass_cnt++;
        total_cnt++;
        if (rnd_out !== 8'h20) $display("FAIL reset_rnd rnd_out=%h expected=20", rnd_out);
        else pass_cnt++;
        total_cnt++;
        if (sample_valid !== 1'b0 || sample_bit !== 1'b0)
            $display("FAIL reset_sample valid=%b bit=%b expected=0/0", sample_valid, sample_bit);
        else pass_cnt++;
    endtask

    task automatic test_lfsr();
        logic [7:0] exp_seq [4];
        logic [7:0] m;
        exp_seq[0] = 8'h20; exp_seq[1] = 8'h41; exp_seq[2] = 8'h82; exp_seq[3] = 8'h05;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if (rnd_out !== exp_seq[i]) $display("FAIL lfsr_seq[%0d] rnd_out=%h expected=%h", i, rnd_out, exp_seq[i]);
            else pass_cnt++;
        end
        // Walk the rest of the period against the reference; it must never hit 0 and return to seed at 255.
        m = 8'h05;
        for (int i = 3; i < 255; i++) begin
            tick();
            m = lfsr_step(m);
            if (rnd_out !== m || rnd_out == 8'h00) begin
                total_cnt++;
                $display("FAIL lfsr_walk[%0d] rnd_out=%h expected=%h", i + 1, rnd_out, m);
            end
        end
        total_cnt++;
        if (rnd_out !== 8'h20) $display("FAIL lfsr_period rnd_out=%h expected=20", rnd_out);
        else pass_cnt++;
    endtask

    task automatic test_sigmoid();
        int         vals  [9];
        logic [7:0] probs [9];
        vals[0] = 0;     probs[0] = 8'd128;
        vals[1] = 255;   probs[1] = 8'd191;
        vals[2] = 256;   probs[2] = 8'd192;
        vals[3] = -256;  probs[3] = 8'd64;
        vals[4] = 607;   probs[4] = 8'd235;
        vals[5] = 608;   probs[5] = 8'd235;
        vals[6] = 1279;  probs[6] = 8'd255;
        vals[7] = 2047;  probs[7] = 8'd255;
        vals[8] = -2047; probs[8] = 8'd0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1;
            load_value = 12'(vals[i]);
            tick();
            load_valid = 1'b0;
            total_cnt++;
            if (acc_out !== 12'(vals[i]) || prob_out !== probs[i])
                $display("FAIL sigmoid[%0d] acc_out=%h prob_out=%0d expected acc=%h prob=%0d",
                         i, acc_out, prob_out, 12'(vals[i]), probs[i]);
            else pass_cnt++;
        end
        // -2048 loaded unclamped: magnitude 2048 must still saturate to probability 0.
        load_valid = 1'b1;
        load_value = 12'h800;
        tick();
        load_valid = 1'b0;
        total_cnt++;
        if (acc_out !== 12'h800 || prob_out !== 8'd0)
            $display("FAIL sigmoid_min acc_out=%h prob_out=%0d expected acc=800 prob=0", acc_out, prob_out);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int ld   [3];
        int ad   [3];
        int res  [3];
        ld[0] = 2000;  ad[0] = 100;  res[0] = 2047;
        ld[1] = -2000; ad[1] = -100; res[1] = -2047;
        ld[2] = 100;   ad[2] = -50;  res[2] = 50;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_value = 12'(ld[i]);
            tick();
            load_valid = 1'b0;
            add_valid  = 1'b1;
            add_value  = 12'(ad[i]);
            tick();
            add_valid  = 1'b0;
            total_cnt++;
            if (acc_out !== 12'(res[i]))
                $display("FAIL saturate[%0d] acc_out=%h expected=%h", i, acc_out, 12'(res[i]));
            else pass_cnt++;
        end
        // Load and add together: load wins.
        load_valid = 1'b1;
        load_value = 12'd300;
        add_valid  = 1'b1;
        add_value  = 12'd500;
        tick();
        clear_inputs();
        total_cnt++;
        if (acc_out !== 12'd300) $display("FAIL load_priority acc_out=%0d expected=300", acc_out);
        else pass_cnt++;
    endtask

    task automatic test_sampling();
        logic [7:0] m;
        int         n;
        // acc=0 (prob 128) against rnd 0x20.
        do_reset();
        sample = 1'b1;
        tick();
        sample = 1'b0;
        total_cnt++;
        if (sample_valid !== 1'b1 || sample_bit !== 1'b1)
            $display("FAIL sample_basic valid=%b bit=%b expected=1/1", sample_valid, sample_bit);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (sample_valid !== 1'b0 || sample_bit !== 1'b1)
            $display("FAIL sample_hold valid=%b bit=%b expected=0/1", sample_valid, sample_bit);
        else pass_cnt++;
        // Probability 0 can never fire.
        load_valid = 1'b1;
        load_value = 12'(-2047);
        tick();
        load_valid = 1'b0;
        sample     = 1'b1;
        tick();
        sample     = 1'b0;
        total_cnt++;
        if (sample_valid !== 1'b1 || sample_bit !== 1'b0)
            $display("FAIL sample_neg valid=%b bit=%b expected=1/0", sample_valid, sample_bit);
        else pass_cnt++;
        // Equal case: run the LFSR to 0x80 with acc=0 (prob 128); strict compare gives 0.
        do_reset();
        m = 8'h20;
        n = 0;
        while (m != 8'h80 && n < 300) begin
            tick();
            m = lfsr_step(m);
            n++;
        end
        total_cnt++;
        if (rnd_out !== 8'h80 || prob_out !== 8'd128)
            $display("FAIL sample_eq_setup rnd_out=%h prob_out=%0d expected rnd=80 prob=128", rnd_out, prob_out);
        else pass_cnt++;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        total_cnt++;
        if (sample_valid !== 1'b1 || sample_bit !== 1'b0)
            $display("FAIL sample_equal valid=%b bit=%b expected=1/0", sample_valid, sample_bit);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp_bits [3];
        // prob 128 vs rnd 0x20, 0x41, 0x82 on successive edges.
        exp_bits[0] = 1'b1; exp_bits[1] = 1'b1; exp_bits[2] = 1'b0;
        do_reset();
        sample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (sample_valid !== 1'b1 || sample_bit !== exp_bits[i])
                $display("FAIL back_to_back[%0d] valid=%b bit=%b expected=1/%b", i, sample_valid, sample_bit, exp_bits[i]);
            else pass_cnt++;
        end
        sample = 1'b0;
        tick();
        total_cnt++;
        if (sample_valid !== 1'b0) $display("FAIL back_to_back_end valid=%b expected=0", sample_valid);
        else pass_cnt++;
    endtask

    task automatic test_sample_with_add();
        // Two edges after reset rnd is 0x82 (130): pre-update prob 128 gives 0, post-update prob 255 would give 1.
        do_reset();
        tick();
        tick();
        total_cnt++;
        if (rnd_out !== 8'h82) $display("FAIL coincident_setup rnd_out=%h expected=82", rnd_out);
        else pass_cnt++;
        sample     = 1'b1;
        add_valid  = 1'b1;
        add_value  = 12'd2047;
        tick();
        clear_inputs();
        total_cnt++;
        if (sample_valid !== 1'b1 || sample_bit !== 1'b0 || acc_out !== 12'd2047)
            $display("FAIL coincident valid=%b bit=%b acc_out=%0d expected=1/0/2047", sample_valid, sample_bit, acc_out);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        load_valid = 1'b1;
        load_value = 12'd500;
        tick();
        load_valid = 1'b0;
        add_valid  = 1'b1;
        add_value  = 12'd100;
        sample     = 1'b1;
        tick();
        total_cnt++;
        if (acc_out !== 12'd600 || sample_valid !== 1'b1)
            $display("FAIL async_pre acc_out=%0d valid=%b expected=600/1", acc_out, sample_valid);
        else pass_cnt++;
        // Mid-cycle reset while add and sample are still requested.
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (acc_out !== 12'd0 || rnd_out !== 8'h20 || sample_valid !== 1'b0 || prob_out !== 8'd128)
            $display("FAIL async_reset acc_out=%0d rnd_out=%h valid=%b prob_out=%0d expected=0/20/0/128",
                     acc_out, rnd_out, sample_valid, prob_out);
        else pass_cnt++;
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        clear_inputs();
        test_reset();
        test_lfsr();
        test_sigmoid();
        test_saturation();
        test_sampling();
        test_back_to_back();
        test_sample_with_add();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stochastic_neuron_core.md
Name: stochastic_neuron_core

Overview:
Single-neuron stochastic evaluation core for the RBM layer datapath. It has three parts:
- a 12-bit signed saturating accumulator (the approximate-precision adder function);
- a piecewise-linear sigmoid that maps the accumulator to an 8-bit firing probability;
- a free-running 8-bit LFSR random source.

On request, the core emits one Bernoulli sample: probability greater than random number.

Parameters:
INF, 12'h7FF, saturation magnitude; accumulator clamps to [-INF, +INF].
SEED, 8'd32, LFSR value loaded on reset; a SEED of 0 loads 8'h01 instead.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load accumulator with load_value (bias)
load_value  input  12  signed bias value
add_valid  input  1  add add_value into accumulator
add_value  input  12  signed addend (already-gated weight)
sample  input  1  request one stochastic sample
acc_out  output  12  signed accumulator register
prob_out  output  8  unsigned sigmoid(acc_out); combinational from acc register
rnd_out  output  8  current LFSR register
sample_valid  output  1  registered one-cycle pulse, asserted one cycle after sample
sample_bit  output  1  registered sample result

Behaviour:
- Reset (asynchronous, active-high): acc=0, LFSR=SEED (or 8'h01 if SEED==0), sample_valid=0, sample_bit=0. Consequently prob_out=128 and rnd_out=SEED during reset.
- Accumulator update, per clock edge when not in reset:
  - load_valid has priority: acc <= load_value, with no clamping.
  - else if add_valid: acc <= clamp(acc + add_value).
  - else hold.
- Clamp: the sum is computed at 13 bits signed. Results above +INF become +INF; results below -INF become -INF. INF=2047, so the minimum is -2047.
- Sigmoid input format: acc is signed fixed point with 8 fraction bits (256 = 1.0).
- Sigmoid computation:
  - a = |acc|, computed as 12-bit unsigned so that -2048 gives 2048.
  - y = 256 if a >= 1280.
  - y = (a>>5) + 216 if 608 <= a < 1280.
  - y = (a>>3) + 160 if 256 <= a < 608.
  - y = (a>>2) + 128 if a < 256.
  - If acc < 0, y = 256 - y.
  - prob_out = min(y, 255).
- LFSR: Fibonacci form, polynomial x^8+x^6+x^5+x^4+1. Every clock: fb = q[7]^q[5]^q[4]^q[3]; q <= {q[6:0], fb}. Period 255; it never reaches 0.
- Sampling: when sample=1 at edge N, the result appears at edge N:
  - sample_valid <= 1 and sample_bit <= (prob_out > rnd_out), using the values present before edge N.
  - The comparison is strictly greater-than, unsigned.
  - Without sample: sample_valid <= 0 and sample_bit holds its previous value.
- Simultaneous sample and load/add in one cycle: the sample uses the pre-update accumulator.
- Back-to-back sample requests produce one pulse per request, with sample_valid staying high continuously.
- Reset asserted mid-operation clears everything immediately; any pending sample is discarded.

Test Plan:
1. LFSR sequence, SEED=32: hold reset, then release. rnd_out is 0x20 after reset, then 0x41, 0x82, 0x05 on successive edges.
2. Sigmoid points (load each value, check prob_out):
   - acc 0 -> 128
   - 255 -> 191
   - 256 -> 192
   - -256 -> 64
   - 607 -> 235
   - 608 -> 235
   - 1279 -> 255
   - 2047 -> 255
   - -2047 -> 0
3. Saturation:
   - Load 2000, add 100 -> acc 2047.
   - Load -2000, add -100 -> -2047.
   - Load 100, add -50 -> 50.
   - Load and add in the same cycle -> load value wins.
4. Sampling:
   - acc=0, rnd=0x20: sample -> next cycle sample_valid=1, sample_bit=1 (128 > 32).
   - acc=-2047: any sample -> sample_bit=0.
   - Equal case prob=rnd=128 -> sample_bit=0.
5. Sample coincident with add: acc=0, sample and add_value=2047 in the same cycle -> the bit is based on prob 128; acc becomes 2047 afterwards.
6. Asynchronous reset asserted mid-accumulation, between clock edges: acc_out=0, rnd_out=0x20 and sample_valid=0 immediately, without waiting for a clock edge.
